vdac_sequencer: RTL

//  Sample-rate sequencer and buffer in front of the vdac voltage-mode DAC.
//  - Accepts offset-binary samples from one producer over a valid/ready handshake.
//  - Buffers them in a small FIFO.
//  - Releases one sample per programmable tick on o_dac_data / o_dac_enable, which connect to the vdac i_data / i_enable.
//  - Handles startup priming, drain-on-stop and underrun, so the analog node never sees an undefined code.

---
 rtl/vdac_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/vdac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vdac_sequencer
//  Purpose  : Sample-rate sequencer and FIFO buffer feeding the vdac DAC.
//             Optional macro VDAC_SEQ_RAMP_EN ramps toward midscale on underrun.
//  Revision : 1.0
// ============================================================================
module vdac_sequencer #(
    parameter int BITWIDTH   = 6,
    parameter int DEPTH_LOG2 = 2,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [BITWIDTH-1:0]  i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_clr_underrun,
    output logic [BITWIDTH-1:0]  o_dac_data,
    output logic                 o_dac_enable,
    output logic                 o_busy,
    output logic                 o_underrun
);

    localparam int                  c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [BITWIDTH-1:0] c_MID   = {1'b1, {(BITWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    logic [BITWIDTH-1:0]   r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DIV_WIDTH-1:0]  r_div_cnt;
    logic [BITWIDTH-1:0]   r_dac_data;
    logic                  r_dac_enable;
    logic                  r_underrun;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_active;
    logic                  w_tick;
    logic                  w_underrun_set;
    logic [BITWIDTH-1:0]   w_head;
    logic [BITWIDTH-1:0]   w_under_data;
    logic [BITWIDTH-1:0]   w_drain_data;
    logic                  w_drain_done;

    assign w_full         = (r_count == c_FULL);
    assign w_empty        = (r_count == '0);
    assign w_push         = i_valid && !w_full;
    assign w_active       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_tick         = w_active && (r_div_cnt == i_div);
    assign w_pop          = w_tick && !w_empty;
    assign w_underrun_set = (r_state == S_RUN) && w_tick && w_empty;
    assign w_head         = r_mem[r_rd_ptr];

`ifdef VDAC_SEQ_RAMP_EN
    // Step one code toward midscale per empty tick to avoid an audible jump.
    logic [BITWIDTH-1:0] w_ramp;
    always_comb begin
        w_ramp = r_dac_data;
        if (r_dac_data < c_MID) begin
            w_ramp = r_dac_data + 1'b1;
        end else if (r_dac_data > c_MID) begin
            w_ramp = r_dac_data - 1'b1;
        end
    end
    assign w_under_data = w_ramp;
    assign w_drain_data = w_ramp;
    assign w_drain_done = (w_ramp == c_MID);
`else
    assign w_under_data = r_dac_data;
    assign w_drain_data = c_MID;
    assign w_drain_done = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_div_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_active) begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            end else begin
                r_div_cnt <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_dac_data   <= c_MID;
            r_dac_enable <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (i_clr_underrun) begin
                r_underrun <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_dac_enable <= 1'b0;
                    r_dac_data   <= c_MID;
                    if (i_start && !i_stop) begin
                        r_state <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    r_dac_enable <= 1'b1;
                    r_dac_data   <= c_MID;
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else if (w_full) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_dac_enable <= 1'b1;
                    if (w_tick) begin
                        r_dac_data <= w_empty ? w_under_data : w_head;
                    end
                    if (i_stop) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_dac_enable <= 1'b1;
                    if (w_tick) begin
                        if (!w_empty) begin
                            r_dac_data <= w_head;
                        end else begin
                            r_dac_data <= w_drain_data;
                            if (w_drain_done) begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready      = !w_full;
    assign o_dac_data   = r_dac_data;
    assign o_dac_enable = r_dac_enable;
    assign o_busy       = (r_state != S_IDLE);
    assign o_underrun   = r_underrun;

endmodule
`default_nettype wire
